// File: rtl/mem_init_pkg.sv
// Shared definitions for the RC4 S-memory initialiser.
//   mode_e  : write-pattern selector (code 2'b11 is reserved and behaves as identity)
//   state_e : initialiser FSM states
//   SEL_*   : S-memory write-port mux codes used by every RC4 phase
package mem_init_pkg;

  typedef enum logic [1:0] {
    MODE_IDENT = 2'b00,
    MODE_DESC  = 2'b01,
    MODE_FILL  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INIT = 2'b01;
  localparam logic [1:0] SEL_KSA  = 2'b10;
  localparam logic [1:0] SEL_PRGA = 2'b11;

endpackage

// File: rtl/init_pattern_gen.sv
// Combinational write-pattern generator, shared with the verify/readback block.
//   mode       in  2         pattern select (mode_e codes, reserved code = identity)
//   cnt        in  ADDR_W+1  current write index
//   fill_value in  DATA_W    constant used in fill mode
//   data       out DATA_W    pattern word for index cnt
module init_pattern_gen
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   cnt,
  input  logic [DATA_W-1:0] fill_value,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  // Size casts truncate or zero-extend the index to the data width.
  always_comb begin
    case (mode)
      MODE_DESC: data = DATA_W'(LAST_CNT - cnt);
      MODE_FILL: data = fill_value;
      default:   data = DATA_W'(cnt);
    endcase
  end

endmodule

// File: rtl/mem_init_gen.sv
// RC4 S-memory initialiser. After start, writes DEPTH words (addresses
// 0..DEPTH-1, one per cycle) using the latched pattern, then pulses done.
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle run request, accepted only in IDLE (abort wins)
//   mode        pattern select, latched with start
//   fill_value  fill constant, latched with start
//   abort       cancels a run; no done pulse follows
//   busy        high while writing
//   done        one-cycle pulse after the last write of a completed run
//   address     write address
//   data        write data
//   wen         write enable
//   sel         SEL_CODE while busy, else SEL_NONE
module mem_init_gen
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter logic [1:0]  SEL_CODE = SEL_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wen,
  output logic [1:0]        sel
);

  // One extra bit so DEPTH = 2**ADDR_W is representable without wrapping.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          sel_q, sel_d;

  logic [1:0]          pat_mode;
  logic [DATA_W-1:0]   pat_fill;
  logic [ADDR_W:0]     pat_cnt;
  logic [DATA_W-1:0]   pat_data;

  // The pattern is evaluated for the index about to be written. In IDLE the
  // live inputs are used so word 0 is correct on the start edge itself.
  always_comb begin
    if (state_q == IDLE) begin
      pat_mode = mode;
      pat_fill = fill_value;
      pat_cnt  = '0;
    end else begin
      pat_mode = mode_q;
      pat_fill = fill_q;
      pat_cnt  = cnt_q + 1'b1;
    end
  end

  init_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pattern (
    .mode       (pat_mode),
    .cnt        (pat_cnt),
    .fill_value (pat_fill),
    .data       (pat_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    address_d = '0;
    data_d    = '0;
    sel_d     = SEL_NONE;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = WRITE;
          cnt_d     = '0;
          mode_d    = mode;
          fill_d    = fill_value;
          busy_d    = 1'b1;
          wen_d     = 1'b1;
          sel_d     = SEL_CODE;
          address_d = pat_cnt[ADDR_W-1:0];
          data_d    = pat_data;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d     = pat_cnt;
          busy_d    = 1'b1;
          wen_d     = 1'b1;
          sel_d     = SEL_CODE;
          address_d = pat_cnt[ADDR_W-1:0];
          data_d    = pat_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      fill_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      sel_q     <= SEL_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      address_q <= address_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wen     = wen_q;
  assign address = address_q;
  assign data    = data_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_mem_init_gen.sv
// Directed bench for mem_init_gen: default 256-word instance plus a
// DATA_W=4/DEPTH=20 instance and a DEPTH=1 instance.
module tb_mem_init_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start2, start3, abort;
  logic [1:0] mode;
  logic [7:0] fill_value;

  logic       busy, done, wen;
  logic [7:0] address, data;
  logic [1:0] sel;

  logic       busy2, done2, wen2;
  logic [7:0] addr2;
  logic [3:0] data2;
  logic [1:0] sel2;

  logic       busy3, done3, wen3;
  logic [7:0] addr3, data3;
  logic [1:0] sel3;

  int checks   = 0;
  int failures = 0;
  logic [7:0] ram [256];

  mem_init_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fill_value(fill_value),
    .abort(abort), .busy(busy), .done(done), .address(address), .data(data),
    .wen(wen), .sel(sel)
  );

  mem_init_gen #(.ADDR_W(8), .DATA_W(4), .DEPTH(20)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .fill_value(fill_value[3:0]),
    .abort(abort), .busy(busy2), .done(done2), .address(addr2), .data(data2),
    .wen(wen2), .sel(sel2)
  );

  mem_init_gen #(.ADDR_W(8), .DATA_W(8), .DEPTH(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .fill_value(fill_value),
    .abort(abort), .busy(busy3), .done(done3), .address(addr3), .data(data3),
    .wen(wen3), .sel(sel3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; start3 = 1'b0; abort = 1'b0;
    mode = 2'b00; fill_value = 8'h00;
    tick(); tick();
    checks++;
    if ({busy, done, wen, address, data, sel} !== 21'h0) begin
      failures++;
      $display("FAIL reset_main: got %h expected 0", {busy, done, wen, address, data, sel});
    end
    checks++;
    if ({busy2, done2, wen2, addr2, data2, sel2} !== 17'h0) begin
      failures++;
      $display("FAIL reset_d20: got %h expected 0", {busy2, done2, wen2, addr2, data2, sel2});
    end
    checks++;
    if ({busy3, done3, wen3, addr3, data3, sel3} !== 21'h0) begin
      failures++;
      $display("FAIL reset_d1: got %h expected 0", {busy3, done3, wen3, addr3, data3, sel3});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    mode = 2'b00; fill_value = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 256; k++) begin
      if (k == 5) begin mode = 2'b01; fill_value = 8'hFF; end
      checks++;
      if (wen !== 1'b1 || address !== 8'(k) || data !== 8'(k) || busy !== 1'b1 ||
          sel !== 2'b01 || done !== 1'b0) begin
        failures++;
        $display("FAIL ident_write k=%0d: wen=%b addr=%h data=%h busy=%b sel=%b done=%b want 1 %h %h 1 01 0",
                 k, wen, address, data, busy, sel, done, 8'(k), 8'(k));
      end
      tick();
    end
    checks++;
    if ({done, wen, busy, sel} !== 5'b10000) begin
      failures++;
      $display("FAIL ident_done: done,wen,busy,sel=%b expected 10000", {done, wen, busy, sel});
    end
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done, wen, busy, sel} !== 5'b00000) begin
        failures++;
        $display("FAIL ident_after: done,wen,busy,sel=%b expected 00000", {done, wen, busy, sel});
      end
    end
    mode = 2'b00;
  endtask

  task automatic test_desc_fill();
    mode = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 256; k++) begin
      checks++;
      if (wen !== 1'b1 || address !== 8'(k) || data !== 8'(255 - k)) begin
        failures++;
        $display("FAIL desc_write k=%0d: wen=%b addr=%h data=%h want 1 %h %h",
                 k, wen, address, data, 8'(k), 8'(255 - k));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL desc_done: done=%b expected 1", done);
    end
    tick();

    for (int unsigned k = 0; k < 256; k++) ram[k] = 8'h00;
    mode = 2'b10; fill_value = 8'hA5;
    start = 1'b1; tick(); start = 1'b0;
    mode = 2'b00; fill_value = 8'h3C;
    for (int unsigned k = 0; k < 256; k++) begin
      if (wen) ram[address] = data;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL fill_done: done=%b expected 1", done);
    end
    tick();
    for (int unsigned k = 0; k < 256; k++) begin
      checks++;
      if (ram[k] !== 8'hA5) begin
        failures++;
        $display("FAIL fill_ram addr=%0d: got %h expected a5", k, ram[k]);
      end
    end
  endtask

  task automatic test_abort();
    mode = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 10; k++) tick();
    checks++;
    if (wen !== 1'b1 || address !== 8'd10) begin
      failures++;
      $display("FAIL abort_pre: wen=%b addr=%h expected 1 0a", wen, address);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({wen, busy, done, sel} !== 5'b00000) begin
      failures++;
      $display("FAIL abort_stop: wen,busy,done,sel=%b expected 00000", {wen, busy, done, sel});
    end
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || wen !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet: done=%b wen=%b expected 0 0", done, wen);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 256; k++) begin
      checks++;
      if (wen !== 1'b1 || address !== 8'(k) || data !== 8'(k)) begin
        failures++;
        $display("FAIL abort_rerun k=%0d: wen=%b addr=%h data=%h want 1 %h %h",
                 k, wen, address, data, 8'(k), 8'(k));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL abort_rerun_done: done=%b expected 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int nwr = 0;
    int ndone = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 256; k++) begin
      if (wen) nwr++;
      if (done) ndone++;
      if (k == 100) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: done=%b expected 1", done);
    end
    if (done) ndone++;
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (wen) nwr++;
      if (done) ndone++;
      tick();
    end
    checks++;
    if (nwr !== 256) begin
      failures++;
      $display("FAIL b2b_writes: got %0d expected 256", nwr);
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_rst_abort();
    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 50; k++) tick();
    checks++;
    if (address !== 8'd50 || wen !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: addr=%h wen=%b expected 32 1", address, wen);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({busy, done, wen, address, data, sel} !== 21'h0) begin
      failures++;
      $display("FAIL rst_mid: got %h expected 0", {busy, done, wen, address, data, sel});
    end
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || wen !== 1'b0) begin
        failures++;
        $display("FAIL rst_quiet: done=%b wen=%b expected 0 0", done, wen);
      end
    end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if (wen !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL start_abort: wen=%b busy=%b expected 0 0", wen, busy);
      end
      tick();
    end
  endtask

  task automatic test_params();
    mode = 2'b00;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      checks++;
      if (wen2 !== 1'b1 || addr2 !== 8'(k) || data2 !== 4'(k) || busy2 !== 1'b1 || sel2 !== 2'b01) begin
        failures++;
        $display("FAIL d20_write k=%0d: wen=%b addr=%h data=%h busy=%b sel=%b want 1 %h %h 1 01",
                 k, wen2, addr2, data2, busy2, sel2, 8'(k), 4'(k));
      end
      if (k == 17) begin
        checks++;
        if (data2 !== 4'h1) begin
          failures++;
          $display("FAIL d20_addr17: data=%h expected 1", data2);
        end
      end
      tick();
    end
    checks++;
    if ({done2, wen2, busy2} !== 3'b100) begin
      failures++;
      $display("FAIL d20_done: done,wen,busy=%b expected 100", {done2, wen2, busy2});
    end
    tick();
    checks++;
    if ({done2, wen2} !== 2'b00) begin
      failures++;
      $display("FAIL d20_after: done,wen=%b expected 00", {done2, wen2});
    end

    start3 = 1'b1; tick(); start3 = 1'b0;
    checks++;
    if ({wen3, addr3, data3, busy3, sel3, done3} !== {1'b1, 8'h00, 8'h00, 1'b1, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL d1_write: wen=%b addr=%h data=%h busy=%b sel=%b done=%b want 1 00 00 1 01 0",
               wen3, addr3, data3, busy3, sel3, done3);
    end
    tick();
    checks++;
    if ({done3, wen3, busy3} !== 3'b100) begin
      failures++;
      $display("FAIL d1_done: done,wen,busy=%b expected 100", {done3, wen3, busy3});
    end
    tick();
    checks++;
    if ({done3, wen3} !== 2'b00) begin
      failures++;
      $display("FAIL d1_after: done,wen=%b expected 00", {done3, wen3});
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_desc_fill();
    test_abort();
    test_back_to_back();
    test_rst_abort();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
